booth_operand_feeder: RTL
=========================

Name: booth_operand_feeder

Overview:
- Issue/capture stage wrapped around the sequential Booth multiplier datapath.
- Accepts signed operand pairs through a valid/ready interface and buffers them in a small FIFO.
- Launches one multiplication at a time with a start pulse, waits the fixed multiplier latency, then captures the product.
- Presents the product on a valid/ready result port with backpressure.

Parameters:
- INPUT_WIDTH, 6, operand width in bits (two's complement).
- OUTPUT_WIDTH, 12, product width; must equal 2*INPUT_WIDTH.
- FIFO_DEPTH, 4, operand FIFO entries; power of two, at least 2.
- MULT_CYCLES, 8, cycles from the start pulse to a valid mul_product_in.

Ports:
- clk_in, input, 1, single clock, rising edge.
- rst_n_in, input, 1, asynchronous active-low reset.
- op_valid_in, input, 1, operand pair valid.
- op_ready_out, output, 1, FIFO can accept.
- multiplicand_in, input, INPUT_WIDTH, signed multiplicand.
- multiplier_in, input, INPUT_WIDTH, signed multiplier.
- mul_start_out, output, 1, one-cycle load/start pulse to the multiplier datapath.
- mul_multiplicand_out, output, INPUT_WIDTH, operand to the datapath.
- mul_multiplier_out, output, INPUT_WIDTH, operand to the datapath.
- mul_product_in, input, OUTPUT_WIDTH, datapath product.
- res_valid_out, output, 1, result valid.
- res_ready_in, input, 1, consumer accepts.
- res_product_out, output, OUTPUT_WIDTH, captured product.
- busy_out, output, 1, high in any state other than IDLE.

Behaviour:
- Reset (asynchronous, rst_n_in=0):
  - FIFO emptied, FSM to IDLE, cycle counter cleared.
  - Outputs forced low: op_ready_out, mul_start_out, res_valid_out and busy_out are 0; mul_*_out and res_product_out are 0.
  - After release, op_ready_out=1 on the first clock.
- Push: on op_valid_in & op_ready_out.
  - op_ready_out = !full, registered-state based; it does not look ahead at a same-cycle pop.
- FSM states:
  - IDLE: if FIFO non-empty, pop the head into the operand registers, drive mul_start_out=1 for that cycle, go to RUN.
  - RUN: counter loads MULT_CYCLES at start and decrements. When it reaches 0, sample mul_product_in into res_product_out and go to HOLD. Sampling happens on the edge ending cycle T+MULT_CYCLES, where T is the start cycle.
  - HOLD: res_valid_out=1. On res_ready_in=1, return to IDLE.
  - Back-to-back: the next start may occur in the cycle following the handshake. Minimum throughput is one result per MULT_CYCLES+2 cycles.
- Timing and stability:
  - mul_*_out are stable from cycle T until the next start.
  - res_product_out and res_valid_out are stable while res_valid_out=1 and res_ready_in=0.
  - res_valid_out rises at T+MULT_CYCLES+1.
- Concurrency and boundaries:
  - A push concurrent with an IDLE pop is allowed. An empty FIFO never pops the same-cycle push.
  - Pushes continue during RUN/HOLD; the FIFO fills to FIFO_DEPTH, giving FIFO_DEPTH+1 operations outstanding, then op_ready_out=0.
  - Pointers are $clog2(FIFO_DEPTH)+1 bits wide and wrap naturally; full means MSBs differ and the rest are equal.
- Counter width is $clog2(MULT_CYCLES+1). No arithmetic is performed on data; products pass through unmodified.
- Reset mid-operation abandons the in-flight product and all queued pairs. No result is emitted.

Optional Feature:
- Macro: BOOTH_FEED_SELFCHECK_EN.
- Defined:
  - The block computes the signed product of the captured operands and compares it with mul_product_in at capture.
  - A mismatch sets a sticky output, err_out (1 bit), which is cleared only by reset.
  - Simulation $error on mismatch.
- Undefined: no err_out port and no comparator; behaviour otherwise identical.

Decomposition:
- Package booth_feed_pkg:
  - FSM state enum {IDLE, RUN, HOLD}.
  - Default width constants.
  - Helper function for counter width.
- Sub-module booth_op_fifo:
  - Parameterised synchronous FIFO of {multiplicand, multiplier}.
  - Ports: push, pop, full, empty.
  - Same clock and asynchronous active-low reset.

Test Plan:
- 5 × 3, res_ready_in=1 → mul_start_out pulse one cycle after the push; res_valid_out at T+9; res_product_out=0x00F; busy_out low afterwards.
- -32 × -32 (0x20, 0x20) → 0x400. 7 × -1 (0x07, 0x3F) → 0xFF9 (−7).
- res_ready_in=0, push 6 pairs back-to-back → op_ready_out falls after the 5th accepted pair (1 in flight plus 4 queued). The 6th pair is stalled until res_ready_in rises. Results come out in push order.
- Hold res_ready_in=0 for 20 cycles → res_product_out and res_valid_out unchanged. mul_start_out does not pulse again until the cycle after the handshake.
- Assert rst_n_in=0 mid-RUN with 3 pairs queued → all outputs 0 immediately (asynchronous). After release op_ready_out=1 and no stale result appears.
- With BOOTH_FEED_SELFCHECK_EN, force mul_product_in wrong by 1 at capture → err_out=1 and stays set until reset.

Source files
------------

// File: rtl/booth_feed_pkg.sv
// rtl/booth_feed_pkg.sv - shared types and default widths for the Booth operand feeder
package booth_feed_pkg;

  typedef enum logic [1:0] {IDLE, RUN, HOLD} state_t;

  localparam int DEF_INPUT_WIDTH  = 6;
  localparam int DEF_OUTPUT_WIDTH = 12;
  localparam int DEF_FIFO_DEPTH   = 4;
  localparam int DEF_MULT_CYCLES  = 8;

  // Counter must hold the value MULT_CYCLES itself, hence the +1.
  function automatic int cnt_width(input int cycles);
    return $clog2(cycles + 1);
  endfunction

endpackage

// File: rtl/booth_op_fifo.sv
// rtl/booth_op_fifo.sv - synchronous operand-pair FIFO
// Pointers carry one extra wrap bit so full and empty are distinguishable.
module booth_op_fifo #(
  parameter int DATA_WIDTH = 12,
  parameter int DEPTH      = 4
) (
  input  logic                  clk_in,
  input  logic                  rst_n_in,
  input  logic                  push,
  input  logic [DATA_WIDTH-1:0] push_data,
  input  logic                  pop,
  output logic [DATA_WIDTH-1:0] pop_data,
  output logic                  full,
  output logic                  empty
);

  localparam int AW = $clog2(DEPTH);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [AW:0]           wr_ptr;
  logic [AW:0]           rd_ptr;

  assign empty    = (wr_ptr == rd_ptr);
  assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign pop_data = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push && !full)
        wr_ptr <= wr_ptr + 1'b1;
      if (pop && !empty)
        rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk_in) begin
    if (push && !full)
      mem[wr_ptr[AW-1:0]] <= push_data;
  end

endmodule

// File: rtl/booth_operand_feeder.sv
// rtl/booth_operand_feeder.sv - issue/capture stage around a sequential Booth multiplier
// Optional product cross-check and sticky err_out under BOOTH_FEED_SELFCHECK_EN.
module booth_operand_feeder
  import booth_feed_pkg::*;
#(
  parameter int INPUT_WIDTH  = DEF_INPUT_WIDTH,
  parameter int OUTPUT_WIDTH = DEF_OUTPUT_WIDTH,
  parameter int FIFO_DEPTH   = DEF_FIFO_DEPTH,
  parameter int MULT_CYCLES  = DEF_MULT_CYCLES
) (
  input  logic                    clk_in,
  input  logic                    rst_n_in,
  input  logic                    op_valid_in,
  output logic                    op_ready_out,
  input  logic [INPUT_WIDTH-1:0]  multiplicand_in,
  input  logic [INPUT_WIDTH-1:0]  multiplier_in,
  output logic                    mul_start_out,
  output logic [INPUT_WIDTH-1:0]  mul_multiplicand_out,
  output logic [INPUT_WIDTH-1:0]  mul_multiplier_out,
  input  logic [OUTPUT_WIDTH-1:0] mul_product_in,
  output logic                    res_valid_out,
  input  logic                    res_ready_in,
  output logic [OUTPUT_WIDTH-1:0] res_product_out,
  output logic                    busy_out
`ifdef BOOTH_FEED_SELFCHECK_EN
  ,
  output logic                    err_out
`endif
);

  localparam int CW = cnt_width(MULT_CYCLES);

  state_t                     state;
  logic [CW-1:0]              cnt;
  logic                       rdy_en;
  logic                       fifo_full;
  logic                       fifo_empty;
  logic                       push;
  logic                       pop;
  logic [2*INPUT_WIDTH-1:0]   head;

  // rdy_en keeps op_ready_out low during reset even though the FIFO is not full.
  assign op_ready_out = rdy_en && !fifo_full;
  assign push         = op_valid_in && op_ready_out;
  assign pop          = !fifo_empty && ((state == IDLE) || (state == HOLD && res_ready_in));
  assign busy_out     = (state != IDLE);

  booth_op_fifo #(
    .DATA_WIDTH (2*INPUT_WIDTH),
    .DEPTH      (FIFO_DEPTH)
  ) u_fifo (
    .clk_in    (clk_in),
    .rst_n_in  (rst_n_in),
    .push      (push),
    .push_data ({multiplicand_in, multiplier_in}),
    .pop       (pop),
    .pop_data  (head),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

`ifdef BOOTH_FEED_SELFCHECK_EN
  logic signed [OUTPUT_WIDTH-1:0] exp_product;
  assign exp_product = $signed(mul_multiplicand_out) * $signed(mul_multiplier_out);
`endif

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state                <= IDLE;
      cnt                  <= '0;
      rdy_en               <= 1'b0;
      mul_start_out        <= 1'b0;
      mul_multiplicand_out <= '0;
      mul_multiplier_out   <= '0;
      res_valid_out        <= 1'b0;
      res_product_out      <= '0;
`ifdef BOOTH_FEED_SELFCHECK_EN
      err_out              <= 1'b0;
`endif
    end else begin
      rdy_en        <= 1'b1;
      mul_start_out <= 1'b0;
      case (state)
        RUN: begin
          if (cnt == '0) begin
            res_product_out <= mul_product_in;
            res_valid_out   <= 1'b1;
            state           <= HOLD;
`ifdef BOOTH_FEED_SELFCHECK_EN
            if (mul_product_in != exp_product) begin
              err_out <= 1'b1;
              $error("booth_operand_feeder: product %0h differs from %0h",
                     mul_product_in, exp_product);
            end
`endif
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        HOLD: begin
          if (res_ready_in) begin
            res_valid_out <= 1'b0;
            state         <= IDLE;
          end
        end
        default: ;
      endcase
      // A pop from IDLE or from a HOLD handshake launches the next product immediately.
      if (pop) begin
        mul_multiplicand_out <= head[2*INPUT_WIDTH-1:INPUT_WIDTH];
        mul_multiplier_out   <= head[INPUT_WIDTH-1:0];
        mul_start_out        <= 1'b1;
        cnt                  <= CW'(MULT_CYCLES);
        state                <= RUN;
      end
    end
  end

endmodule
